matvec_iter_sched: RTL

Sequencer and arbiter for the shared 2x2 binary (GF(2)) matrix-vector multiplier `matrix_vec_mul`. Two requesters each submit a matrix, a vector and an iteration count. The block grants one requester at a time using round-robin arbitration. It then applies the matrix to the vector repeatedly, one multiply per clock, and returns M^k·v through a valid/ready response port. It sits between requester logic and a single `matrix_vec_mul` instance, so the combinational multiplier is reused instead of replicated.

---
 rtl/matvec_iter_sched.sv | 132 +++++++++++++
 1 files changed

// File: rtl/matvec_iter_sched.sv
// Round-robin sequencer that shares one 2x2 GF(2) matrix-vector multiplier between two
// requesters and iterates it k times per job, returning M^k * v on a valid/ready port.

module matrix_vec_mul (
    input  logic [3:0] mat_i,
    input  logic [1:0] vec_i,
    output logic [1:0] vec_o
);
    assign vec_o[1] = (mat_i[3] & vec_i[1]) ^ (mat_i[2] & vec_i[0]);
    assign vec_o[0] = (mat_i[1] & vec_i[1]) ^ (mat_i[0] & vec_i[0]);
endmodule

module matvec_iter_sched #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_mat,
    input  logic [1:0]       req0_vec,
    input  logic [CNT_W-1:0] req0_cnt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_mat,
    input  logic [1:0]       req1_vec,
    input  logic [CNT_W-1:0] req1_cnt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [1:0]       rsp_vec
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       mat_q, mat_d;
    logic [1:0]       vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic             grant0, grant1;
    logic [1:0]       mul_out;
    logic [CNT_W-1:0] acc_cnt;

    matrix_vec_mul u_mul (
        .mat_i (mat_q),
        .vec_i (vec_q),
        .vec_o (mul_out)
    );

    // On a tie the requester that was not served last wins.
    assign grant0 = req0_valid & (~req1_valid | last_grant_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

    assign req0_ready = rst_n & (state_q == StIdle) & grant0;
    assign req1_ready = rst_n & (state_q == StIdle) & grant1;

    assign acc_cnt = grant1 ? req1_cnt : req0_cnt;

    always_comb begin
        state_d      = state_q;
        mat_d        = mat_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        case (state_q)
            StIdle: begin
                if (req0_ready || req1_ready) begin
                    mat_d        = grant1 ? req1_mat : req0_mat;
                    vec_d        = grant1 ? req1_vec : req0_vec;
                    cnt_d        = acc_cnt;
                    id_d         = grant1;
                    last_grant_d = grant1;
                    if (acc_cnt == '0) begin
                        state_d     = StDone;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                vec_d = mul_out;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) begin
                    state_d     = StDone;
                    rsp_valid_d = 1'b1;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = StIdle;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mat_q        <= 4'b0000;
            vec_q        <= 2'b00;
            cnt_q        <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mat_q        <= mat_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_vec   = vec_q;
    assign rsp_id    = id_q;
endmodule
